// File: rtl/sccb_cfg_sequencer.sv
// Walks a {rega, value} register table and feeds each write to the SCCB engine.
// In-table markers: 16'hFFFF ends the table, 16'hFFF0 inserts a fixed delay.
module sccb_cfg_sequencer #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned DELAY_MS   = 10,
  parameter int unsigned PWRUP_CYC  = 1000000,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              send,
  input  logic              taken,
  output logic [7:0]        rega,
  output logic [7:0]        value,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned DELAY_CYC = CLK_HZ / 1000 * DELAY_MS;
  localparam int unsigned CNT_MAX   = (DELAY_CYC > PWRUP_CYC) ? DELAY_CYC : PWRUP_CYC;
  localparam int unsigned CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [15:0]       END_MARK   = 16'hFFFF;
  localparam logic [15:0]       DELAY_MARK = 16'hFFF0;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWRUP,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_DELAY,
    S_DONE
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] rom_addr_d;
  logic [7:0]        rega_d, value_d;
  logic              send_d, busy_d, done_d, err_d;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    rom_addr_d = rom_addr;
    rega_d     = rega;
    value_d    = value;
    err_d      = err;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          rom_addr_d = '0;
        end else if (AUTO_START) begin
          state_d = S_PWRUP;
          cnt_d   = CNT_W'(PWRUP_CYC);
        end
      end

      S_PWRUP: begin
        if (cnt <= CNT_W'(1)) begin
          state_d    = S_FETCH;
          rom_addr_d = '0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end

      // rom_data for the new address arrives one cycle after rom_addr moves.
      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        if (rom_data == END_MARK) begin
          state_d = S_DONE;
          err_d   = 1'b0;
        end else if (rom_data == DELAY_MARK) begin
          state_d = S_DELAY;
          cnt_d   = CNT_W'(DELAY_CYC);
        end else begin
          state_d = S_SEND;
          rega_d  = rom_data[15:8];
          value_d = rom_data[7:0];
        end
      end

      S_SEND: begin
        if (taken) begin
          if (rom_addr == LAST_ADDR) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d    = S_FETCH;
            rom_addr_d = rom_addr + ADDR_W'(1);
          end
        end
      end

      S_DELAY: begin
        if (cnt <= CNT_W'(1)) begin
          if (rom_addr == LAST_ADDR) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d    = S_FETCH;
            rom_addr_d = rom_addr + ADDR_W'(1);
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end

      S_DONE: begin
        if (start) begin
          state_d    = S_FETCH;
          rom_addr_d = '0;
          err_d      = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    send_d = (state_d == S_SEND);
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rom_addr <= '0;
      rega     <= '0;
      value    <= '0;
      send     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      rom_addr <= rom_addr_d;
      rega     <= rega_d;
      value    <= value_d;
      send     <= send_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Bench for sccb_cfg_sequencer: table ROM model, SCCB engine model with a
// write scoreboard, vector table of table runs, and hand-written corner cases.
module tb_sccb_cfg_sequencer;

  localparam int unsigned ADDR_W = 2;

  logic              clk, rst_n;
  logic              start, taken, start2, taken2;
  logic [ADDR_W-1:0] rom_addr, rom_addr2;
  logic [15:0]       rom_data, rom_data2;
  logic              send, busy, done, err;
  logic              send2, busy2, done2, err2;
  logic [7:0]        rega, value, rega2, value2;

  logic [15:0] mem [4];
  logic [15:0] exp_q [$];

  int checks   = 0;
  int failures = 0;

  // Auto-start instance: 10-cycle power-up, DELAY_CYC = 20000/1000*1 = 20.
  sccb_cfg_sequencer #(
    .ADDR_W(ADDR_W), .CLK_HZ(20000), .DELAY_MS(1), .PWRUP_CYC(10), .AUTO_START(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .send(send), .taken(taken), .rega(rega), .value(value),
    .busy(busy), .done(done), .err(err)
  );

  // Manual-start instance sharing the same table and reset.
  sccb_cfg_sequencer #(
    .ADDR_W(ADDR_W), .CLK_HZ(20000), .DELAY_MS(1), .PWRUP_CYC(10), .AUTO_START(1'b0)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .send(send2), .taken(taken2), .rega(rega2), .value(value2),
    .busy(busy2), .done(done2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous table ROM: data valid one cycle after the address changes.
  always @(posedge clk) begin
    rom_data  <= mem[rom_addr];
    rom_data2 <= mem[rom_addr2];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Engine model: takes each write take_dly cycles after send rises.
  int          cyc = 0, eng_cnt = 0, take_dly = 5, n_sends = 0, last_take = 0, gap = 0;
  logic        send_q = 1'b0, have_take = 1'b0;
  logic [15:0] held = '0;

  initial taken = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      taken     = 1'b0;
      eng_cnt   = 0;
      send_q    = 1'b0;
      have_take = 1'b0;
    end else if (taken) begin
      taken = 1'b0;
      check("send_drop_after_taken", 32'(send), 32'(1'b0));
      send_q = send;
    end else begin
      if (send) begin
        if (!send_q) begin
          held = {rega, value};
          if (have_take) gap = cyc - last_take;
        end
        check("rega_value_hold", 32'({rega, value}), 32'(held));
        eng_cnt++;
        if (eng_cnt >= take_dly) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_send: actual=0x%04h required=none", {rega, value});
          end else begin
            check("write_word", 32'({rega, value}), 32'(exp_q.pop_front()));
          end
          taken     = 1'b1;
          eng_cnt   = 0;
          n_sends++;
          last_take = cyc;
          have_take = 1'b1;
        end
      end else begin
        if (send_q) check("send_held_until_taken", 32'(send), 32'(1'b1));
        if (done) have_take = 1'b0;
        eng_cnt = 0;
      end
      send_q = send;
    end
  end

  typedef struct {
    logic [3:0][15:0] tbl;
    int               take_dly;
    int               exp_sends;
    logic             exp_err;
    logic [1:0]       exp_addr;
    int               exp_gap;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] w0, w1, w2, w3, input int dly, sends,
                              input logic e, input logic [1:0] a, input int g);
    vec_t v;
    v.tbl[0] = w0; v.tbl[1] = w1; v.tbl[2] = w2; v.tbl[3] = w3;
    v.take_dly = dly; v.exp_sends = sends; v.exp_err = e; v.exp_addr = a; v.exp_gap = g;
    return v;
  endfunction

  task automatic load_table(input vec_t v);
    for (int i = 0; i < 4; i++) mem[i] = v.tbl[i];
  endtask

  // Expected writes: every word up to the first end marker, skipping delays.
  task automatic push_expected();
    for (int i = 0; i < 4; i++) begin
      if (mem[i] == 16'hFFFF) break;
      if (mem[i] != 16'hFFF0) exp_q.push_back(mem[i]);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(done), 32'(1'b1));
  endtask

  task automatic wait_send(input string name, input int budget);
    int k = 0;
    while (!send && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(send), 32'(1'b1));
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    int          base, k, a, idle_bad;
    logic [15:0] w2 [2];

    vecs[0] = mk(16'h1280, 16'h1201, 16'hFFFF, 16'h0000,   5, 2, 1'b0, 2'd2,  3);
    vecs[1] = mk(16'h1280, 16'h1201, 16'hFFFF, 16'h0000, 500, 2, 1'b0, 2'd2,  3);
    vecs[2] = mk(16'h1180, 16'hFFF0, 16'h1100, 16'hFFFF,   5, 2, 1'b0, 2'd3, 25);
    vecs[3] = mk(16'h0101, 16'h0202, 16'h0303, 16'h0404,   5, 4, 1'b1, 2'd3,  3);
    vecs[4] = mk(16'h0101, 16'h0202, 16'h0303, 16'hFFF0,   5, 3, 1'b1, 2'd3,  3);
    vecs[5] = mk(16'hFFFF, 16'h1234, 16'h5678, 16'h9ABC,   5, 0, 1'b0, 2'd0,  0);

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; taken2 = 1'b0;
    take_dly = 5;
    load_table(vecs[0]);
    push_expected();
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_send", 32'(send), 32'd0);
    check("rst_rega_value", 32'({rega, value}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Auto-start: IDLE -> PWRUP(10) -> FETCH -> DECODE -> SEND
    rst_n = 1'b1;
    @(negedge clk);
    check("pwrup_busy", 32'(busy), 32'd1);
    k = 1;
    while (!send && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("first_send_latency", 32'(k), 32'd13);
    wait_done("autostart_done", 2000);
    check("autostart_err", 32'(err), 32'd0);
    check("autostart_rom_addr", 32'(rom_addr), 32'd2);
    check("autostart_busy", 32'(busy), 32'd0);
    check("autostart_sends", 32'(n_sends), 32'd2);
    check("autostart_q_empty", 32'(exp_q.size()), 32'd0);
    check("dut2_idle_after_reset", 32'({busy2, send2, done2}), 32'd0);

    // Table-driven restarts from DONE
    for (int i = 0; i < 6; i++) begin
      load_table(vecs[i]);
      take_dly = vecs[i].take_dly;
      push_expected();
      base = n_sends;
      pulse_start();
      check($sformatf("v%0d_restart", i), 32'({busy, done, 2'(rom_addr)}), 32'b1000);
      wait_done($sformatf("v%0d_done", i), 5000);
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_rom_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
      check($sformatf("v%0d_sends", i), 32'(n_sends - base), 32'(vecs[i].exp_sends));
      check($sformatf("v%0d_q_empty", i), 32'(exp_q.size()), 32'd0);
      check($sformatf("v%0d_idle_outputs", i), 32'({busy, send}), 32'd0);
      if (vecs[i].exp_gap != 0)
        check($sformatf("v%0d_taken_to_send", i), 32'(gap), 32'(vecs[i].exp_gap));
    end

    // start pulse while a write is pending changes nothing
    load_table(vecs[0]);
    take_dly = 40;
    push_expected();
    base = n_sends;
    pulse_start();
    wait_send("mid_send_reach", 50);
    a = 32'(rom_addr);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("mid_start_state", 32'({send, busy, done}), 32'b110);
    check("mid_start_rom_addr", 32'(rom_addr), 32'(a));
    wait_done("mid_start_done", 2000);
    check("mid_start_sends", 32'(n_sends - base), 32'd2);
    check("mid_start_q_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset during SEND
    push_expected();
    pulse_start();
    wait_send("reset_send_reach", 50);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 32'({send, busy, done, err}), 32'd0);
    check("async_rst_rom_addr", 32'(rom_addr), 32'd0);
    check("async_rst_rega_value", 32'({rega, value}), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    take_dly = 5;
    push_expected();
    rst_n = 1'b1;
    @(negedge clk);
    check("rerun_pwrup_busy", 32'(busy), 32'd1);
    idle_bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (busy2 || send2 || done2 || rom_addr2 != '0) idle_bad++;
    end
    check("dut2_stays_idle", 32'(idle_bad), 32'd0);
    wait_done("rerun_done", 2000);
    check("rerun_err_addr", 32'({err, 2'(rom_addr)}), 32'b010);

    // Manual-start instance: stray taken ignored, then run the table by hand
    @(negedge clk) taken2 = 1'b1;
    @(negedge clk) taken2 = 1'b0;
    check("dut2_taken_ignored", 32'({busy2, send2, 2'(rom_addr2)}), 32'd0);
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    check("dut2_start", 32'({busy2, done2, 2'(rom_addr2)}), 32'b1000);
    w2[0] = 16'h1280;
    w2[1] = 16'h1201;
    for (int j = 0; j < 2; j++) begin
      k = 0;
      while (!send2 && k < 20) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("dut2_send%0d", j), 32'(send2), 32'd1);
      check($sformatf("dut2_word%0d", j), 32'({rega2, value2}), 32'(w2[j]));
      taken2 = 1'b1;
      @(negedge clk) taken2 = 1'b0;
      check($sformatf("dut2_drop%0d", j), 32'(send2), 32'd0);
    end
    k = 0;
    while (!done2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("dut2_done", 32'({done2, busy2, err2, 2'(rom_addr2)}), 32'b10010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
